// File: rtl/node_update_seq.sv
// rtl/node_update_seq.sv - sequential multi-lane, multi-plane p-bit node updater
module node_update_seq #(
    parameter int PRECISION_BITS  = 4,
    parameter int OVERFLOW_BITS   = 4,
    parameter int P_INDEX         = 3,
    parameter int NUM_NODES       = 16,
    parameter int NUM_COLORS_BITS = 2,
    parameter int LANES           = 4,
    parameter int P_OUT           = 15,
    parameter int RNG_LEN         = 32,
    parameter logic [RNG_LEN-1:0] SEED = RNG_LEN'(2)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          rst_state,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [NUM_NODES*NUM_COLORS_BITS-1:0]          nodes,
    input  logic [NUM_COLORS_BITS*NUM_NODES*PRECISION_BITS-1:0] weights,
    input  logic [NUM_COLORS_BITS*PRECISION_BITS-1:0]     bias,
    input  logic [2:0]                                    beta_shift,
    input  logic                                          greedy,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [NUM_COLORS_BITS-1:0]                    new_color,
    output logic [NUM_COLORS_BITS*(PRECISION_BITS+OVERFLOW_BITS)-1:0] field_out,
    output logic                                          busy
);
    function automatic logic [63:0] rng_taps(input int len);
        case (len)
            8:       rng_taps = 64'hB8;
            16:      rng_taps = 64'hB400;
            24:      rng_taps = 64'hE10000;
            64:      rng_taps = 64'hD800000000000000;
            default: rng_taps = 64'h80200003;
        endcase
    endfunction

    localparam int PB    = PRECISION_BITS;
    localparam int NCB   = NUM_COLORS_BITS;
    localparam int ACC_W = PRECISION_BITS + OVERFLOW_BITS;
    localparam int C     = NUM_NODES / LANES;
    localparam int CW    = (C > 1) ? $clog2(C) : 1;
    localparam int BW    = (NCB > 1) ? $clog2(NCB) : 1;
    localparam int YSH   = P_OUT - 2 - P_INDEX;
    localparam logic signed [31:0] ACC_MAX = (32'sd1 <<< (ACC_W - 1)) - 32'sd1;
    localparam logic signed [31:0] ACC_MIN = -(32'sd1 <<< (ACC_W - 1));
    localparam logic signed [31:0] Y_HALF  = 32'sd1 <<< (P_OUT - 1);
    localparam logic signed [31:0] Y_FULL  = 32'sd1 <<< P_OUT;
    localparam logic [RNG_LEN-1:0] TAPS    = RNG_LEN'(rng_taps(RNG_LEN));

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [31:0] x);
        if (x > ACC_MAX)      sat_acc = ACC_W'(ACC_MAX);
        else if (x < ACC_MIN) sat_acc = ACC_W'(ACC_MIN);
        else                  sat_acc = x[ACC_W-1:0];
    endfunction

    typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, DONE} state_t;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   k_q, k_d;
    logic [BW-1:0]                   plane_q, plane_d;
    logic signed [ACC_W-1:0]         acc_q, acc_d;
    logic [NUM_NODES*NCB-1:0]        nodes_q, nodes_d;
    logic [NCB*NUM_NODES*PB-1:0]     weights_q, weights_d;
    logic [NCB*PB-1:0]               bias_q, bias_d;
    logic [2:0]                      beta_q, beta_d;
    logic                            greedy_q, greedy_d;
    logic [NCB-1:0]                  new_color_q, new_color_d;
    logic [NCB*ACC_W-1:0]            field_q, field_d;
    logic [RNG_LEN-1:0]              lfsr_q, lfsr_d;
    logic                            live_q, live_d;

    logic signed [31:0]              lane_sum;
    logic signed [ACC_W-1:0]         acc_next;
    logic signed [PB-1:0]            bias_b;
    logic signed [31:0]              pre_shift;
    logic signed [ACC_W-1:0]         f_val;
    logic signed [31:0]              y_wide;
    logic [P_OUT:0]                  y_val;
    logic                            dec_bit;
    logic                            lfsr_fb;

    // Datapath: one chunk of LANES products per ACCUM cycle, decision maths for DECIDE
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            if (nodes_q[(int'(k_q) * LANES + l) * NCB + int'(plane_q)])
                lane_sum = lane_sum + 32'(signed'(
                    weights_q[(int'(plane_q) * NUM_NODES + int'(k_q) * LANES + l) * PB +: PB]));
        end
        acc_next  = sat_acc(32'(acc_q) + lane_sum);
        bias_b    = bias_q[int'(plane_q) * PB +: PB];
        pre_shift = (32'(acc_q) + 32'(bias_b)) <<< beta_q;
        f_val     = sat_acc(pre_shift);
        y_wide    = Y_HALF + (32'(f_val) <<< YSH);
        if (y_wide < 32'sd0)       y_val = '0;
        else if (y_wide > Y_FULL)  y_val = (P_OUT + 1)'(Y_FULL);
        else                       y_val = y_wide[P_OUT:0];
        if (greedy_q) dec_bit = !f_val[ACC_W-1] && (f_val != '0);
        else          dec_bit = y_val > {1'b0, lfsr_q[P_OUT-1:0]};
        lfsr_fb = ^(lfsr_q & TAPS);
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        plane_d     = plane_q;
        acc_d       = acc_q;
        nodes_d     = nodes_q;
        weights_d   = weights_q;
        bias_d      = bias_q;
        beta_d      = beta_q;
        greedy_d    = greedy_q;
        new_color_d = new_color_q;
        field_d     = field_q;
        lfsr_d      = lfsr_q;
        live_d      = 1'b1;
        in_ready    = (state_q == IDLE) && live_q;
        out_valid   = (state_q == DONE);
        busy        = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    nodes_d   = nodes;
                    weights_d = weights;
                    bias_d    = bias;
                    beta_d    = beta_shift;
                    greedy_d  = greedy;
                    acc_d     = '0;
                    k_d       = '0;
                    plane_d   = '0;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_next;
                if (k_q == CW'(C - 1)) state_d = DECIDE;
                else                   k_d = k_q + 1'b1;
            end
            DECIDE: begin
                field_d[int'(plane_q) * ACC_W +: ACC_W] = f_val;
                new_color_d[plane_q] = dec_bit;
                if (!greedy_q) lfsr_d = {lfsr_q[RNG_LEN-2:0], lfsr_fb};
                if (plane_q == BW'(NCB - 1)) begin
                    state_d = DONE;
                end else begin
                    plane_d = plane_q + 1'b1;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = ACCUM;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reseed takes priority over a coincident advance
        if (rst_state) lfsr_d = SEED;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            plane_q     <= '0;
            acc_q       <= '0;
            nodes_q     <= '0;
            weights_q   <= '0;
            bias_q      <= '0;
            beta_q      <= '0;
            greedy_q    <= 1'b0;
            new_color_q <= '0;
            field_q     <= '0;
            lfsr_q      <= SEED;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            plane_q     <= plane_d;
            acc_q       <= acc_d;
            nodes_q     <= nodes_d;
            weights_q   <= weights_d;
            bias_q      <= bias_d;
            beta_q      <= beta_d;
            greedy_q    <= greedy_d;
            new_color_q <= new_color_d;
            field_q     <= field_d;
            lfsr_q      <= lfsr_d;
            live_q      <= live_d;
        end
    end

    assign new_color = new_color_q;
    assign field_out = field_q;
endmodule

// File: doc/node_update_seq.md
Name: node_update_seq

Overview:
- Multi-lane, sequential successor to the single-node p-bit updater, for integer-state (multi-colour) optimisation.
- Accepts one node-update request per handshake and evaluates each colour bit-plane in turn. Per plane: time-multiplexed dot product over NUM_NODES using LANES MACs/cycle, then bias add, temperature shift, saturating piecewise-linear sigmoid and an LFSR compare.
- Adds a greedy (deterministic) mode and valid/ready flow control on both sides.
- Sits between the node-state memory and the scheduler/hitting-time engine.

Parameters:
- PRECISION_BITS, 4, signed weight/bias width
- OVERFLOW_BITS, 4, guard bits; ACC_W = PRECISION_BITS+OVERFLOW_BITS
- P_INDEX, 3, fractional bits of field
- NUM_NODES, 16, nodes per dot product; must be divisible by LANES
- NUM_COLORS_BITS, 2, bits per node state (bit-planes)
- LANES, 4, MACs per cycle; C = NUM_NODES/LANES
- P_OUT, 15, sigmoid/random fractional bits; requires P_OUT-2 >= P_INDEX
- RNG_LEN, 32, LFSR length; taps from RNG_TAPS(RNG_LEN)
- SEED, 2, LFSR seed; nonzero

Ports:
- clk  in  1  machine clock
- rst  in  1  asynchronous, active-low reset
- rst_state  in  1  synchronous LFSR reseed to SEED; does not abort an update
- in_valid  in  1  request valid
- in_ready  out  1  high only in IDLE
- nodes  in  NUM_NODES*NUM_COLORS_BITS  node states; node j bits at [j*NCB +: NCB]
- weights  in  NUM_COLORS_BITS*NUM_NODES*PRECISION_BITS  signed; plane b, node j at [(b*NUM_NODES+j)*PB +: PB]
- bias  in  NUM_COLORS_BITS*PRECISION_BITS  signed per-plane bias
- beta_shift  in  3  left shift on field (inverse temperature)
- greedy  in  1  1 = deterministic decision
- out_valid  out  1  result valid
- out_ready  in  1  consumer accept
- new_color  out  NUM_COLORS_BITS  new node state
- field_out  out  NUM_COLORS_BITS*ACC_W  final signed field per plane (for hitting-time engine)
- busy  out  1  state != IDLE

Behaviour:
- Input capture:
  - nodes, weights, bias, beta_shift and greedy are registered on accept (in_valid & in_ready).
  - Inputs may change afterwards.
- FSM: IDLE -> ACCUM -> DECIDE -> (ACCUM for next plane | DONE) -> IDLE.
  - IDLE: in_ready=1. Accept clears acc, sets plane b=0 and chunk k=0.
  - ACCUM: term_j = node j bit b ? weight[b][j] : 0. Sum LANES terms (chunk k) at full width, then acc = sat_ACC_W(acc + lane_sum). k runs 0..C-1; after k=C-1 go to DECIDE.
  - DECIDE (1 cycle):
    - f = sat_ACC_W((acc + sext(bias[b])) << beta_shift), where the shift is computed at full width before saturation.
    - Store f in field_out plane b.
    - greedy=1: bit = (f > 0).
    - greedy=0: y = clamp(2^(P_OUT-1) + f*2^(P_OUT-2-P_INDEX), 0, 2^P_OUT) on P_OUT+1 bits; bit = y > {1'b0, rand[P_OUT-1:0]}.
    - Store bit into new_color[b]. If b < NCB-1: b++, clear acc and k, go to ACCUM; else go to DONE.
  - DONE: out_valid=1. new_color and field_out are held stable until out_ready. On out_valid & out_ready, go to IDLE next cycle.
- No same-cycle accept in DONE; throughput is one update per NCB*(C+1)+2 cycles.
- Latency: accept at cycle T gives out_valid at T+1+NCB*(C+1). Defaults: T+11.
- LFSR:
  - Fibonacci with taps RNG_TAPS(RNG_LEN); output is low P_OUT bits.
  - Advances exactly once per DECIDE cycle with greedy=0; otherwise holds.
  - rst or rst_state loads SEED. If rst_state and an advance coincide, reseed wins.
- Saturation: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; never wrap.
- Reset (async, any state): state=IDLE; out_valid=0, new_color=0, field_out=0, busy=0, acc=0, LFSR=SEED. in_ready=1 from the first edge after release.
- Back-pressure: out_ready low holds DONE indefinitely; in_valid is ignored while busy.

Test Plan:
1. rst low during ACCUM plane 1 -> out_valid=0, new_color=0, field_out=0 immediately; in_ready=1 after release; next request completes normally with latency 11.
2. Greedy: nodes all 2'b11, plane-0 weights all 4'sd1, plane-1 all -1, bias 0, beta_shift 0 -> out_valid at T+11, field_out={-16,16}, new_color=2'b01.
3. Saturation: weights all 4'sd7, bias 7, beta_shift 1, stochastic -> f=+127, y=32768 -> new_color=2'b11 for any LFSR value; bias -8, weights -8, beta_shift 0 -> f=-128, y=0, new_color=2'b00.
4. Back-pressure: out_ready low 5 cycles, in_valid pulsed -> out_valid/new_color/field_out stable, in_ready=0, pulses not accepted; release -> IDLE next cycle.
5. Statistics: f=0 (nodes 0, bias 0), 2000 stochastic updates -> each bit ~50% ±4%. Repeat after rst_state -> bit sequence identical to first run.
6. Greedy draw count: greedy updates interleaved with stochastic -> stochastic bit sequence equals an all-stochastic run (LFSR not advanced in greedy).
